motor_pwm_ramp: RTL and testbench

Parametrised multi-channel H-bridge PWM driver. It is the next generation of the two-channel 10-bit motor PWM controller. It adds per-channel slew-rate limiting of the applied duty, enforced dead-time on direction reversal, and an explicit brake input. It sits between the drive/steering controller and the H-bridge gate pins. Each channel takes a sign-magnitude command (bit W = reverse) and drives a fwd/rev pin pair.

---
 rtl/motor_pwm_ramp.sv | 159 +++++++++++++++
 tb/tb_motor_pwm_ramp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_ramp.sv
// motor_pwm_ramp: multi-channel H-bridge PWM driver with slew-limited duty,
// dead-time on direction reversal and a per-channel brake.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset, sampled on posedge clk
//   cmd        per-channel sign-magnitude command, channel i = cmd[i*(W+1) +: W+1]
//              (bit W = reverse, bits W-1:0 = magnitude)
//   brake      per-channel immediate brake request
//   fwd        forward gate drive per channel (registered)
//   rev        reverse gate drive per channel (registered)
//   duty_mon   applied magnitude per channel, channel i = duty_mon[i*W +: W]
//   period_end high while the shared PWM counter is at its last count
module motor_pwm_ramp #(
   parameter int unsigned CH   = 2,
   parameter int unsigned W    = 10,
   parameter int unsigned STEP = 8,
   parameter int unsigned DEAD = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH*(W+1)-1:0] cmd,
   input  logic [CH-1:0]       brake,
   output logic [CH-1:0]       fwd,
   output logic [CH-1:0]       rev,
   output logic [CH*W-1:0]     duty_mon,
   output logic                period_end
);

   localparam int unsigned CW = W + 1;
   localparam int unsigned DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
   localparam logic [W-1:0]  CNT_MAX = '1;
   localparam logic [W:0]    STEP_X  = CW'(STEP);
   localparam logic [DW-1:0] DEAD_X  = DW'(DEAD);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_DEAD = 1'b1
   } state_t;

   logic [W-1:0] cnt;
   logic         boundary;

   // Shared PWM counter; the last count of each period is the update boundary.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign boundary   = (cnt == CNT_MAX);
   assign period_end = boundary;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [W-1:0]  mag;
      logic          dir;
      state_t        state;
      logic [DW-1:0] dead_cnt;
      logic          fwd_q;
      logic          rev_q;
      logic          tdir;
      logic [W-1:0]  tmag;
      logic [W:0]    toward_delta;
      logic [W:0]    decay_delta;
      logic [W-1:0]  mag_toward;
      logic [W-1:0]  mag_decay;
      logic          pwm_on;

      assign tdir   = cmd[i*CW + W];
      assign tmag   = cmd[i*CW +: W];
      assign pwm_on = (mag > cnt);

      // Candidate boundary values: one clamped step toward tmag, or one clamped step toward 0.
      // Done in W+1 bits so neither direction can wrap.
      always_comb begin
         toward_delta = '0;
         decay_delta  = '0;
         mag_toward   = mag;
         mag_decay    = mag;
         if (tmag >= mag) begin
            toward_delta = {1'b0, tmag} - {1'b0, mag};
            if (toward_delta > STEP_X) begin
               toward_delta = STEP_X;
            end
            mag_toward = W'({1'b0, mag} + toward_delta);
         end else begin
            toward_delta = {1'b0, mag} - {1'b0, tmag};
            if (toward_delta > STEP_X) begin
               toward_delta = STEP_X;
            end
            mag_toward = W'({1'b0, mag} - toward_delta);
         end
         decay_delta = (STEP_X < {1'b0, mag}) ? STEP_X : {1'b0, mag};
         mag_decay   = W'({1'b0, mag} - decay_delta);
      end

      // Channel FSM (RUN / DEAD) with registered gate drives.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            mag      <= '0;
            dir      <= 1'b0;
            state    <= S_RUN;
            dead_cnt <= '0;
            fwd_q    <= 1'b0;
            rev_q    <= 1'b0;
         end else begin
            // Gate drives from this cycle's register values, highest priority first.
            if (brake[i]) begin
               fwd_q <= 1'b1;
               rev_q <= 1'b1;
            end else if (state == S_DEAD) begin
               fwd_q <= 1'b0;
               rev_q <= 1'b0;
            end else if (mag == '0) begin
               fwd_q <= 1'b1;
               rev_q <= 1'b1;
            end else if (!dir) begin
               fwd_q <= pwm_on;
               rev_q <= 1'b0;
            end else begin
               fwd_q <= 1'b0;
               rev_q <= pwm_on;
            end

            // Brake overrides everything; DEAD blocks boundary updates until it expires.
            if (brake[i]) begin
               mag      <= '0;
               state    <= S_RUN;
               dead_cnt <= '0;
            end else if (state == S_DEAD) begin
               dead_cnt <= dead_cnt - DW'(1);
               if (dead_cnt == DW'(1)) begin
                  state <= S_RUN;
               end
            end else if (boundary) begin
               if ((tmag == '0) || (tdir == dir)) begin
                  mag <= mag_toward;
               end else if (mag != '0) begin
                  // Reversal requested: wind down in the current direction first.
                  mag <= mag_decay;
               end else begin
                  dir <= tdir;
                  if (DEAD > 0) begin
                     state    <= S_DEAD;
                     dead_cnt <= DEAD_X;
                  end
               end
            end
         end
      end

      assign fwd[i]            = fwd_q;
      assign rev[i]            = rev_q;
      assign duty_mon[i*W +: W] = mag;
   end

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// tb_motor_pwm_ramp: self-checking bench for motor_pwm_ramp.
// Two instances share clk/rst_n: A (CH=2, W=10, STEP=8, DEAD=16) and
// B (CH=1, W=10, STEP=1000, DEAD=0) for the saturation and no-dead-time cases.
// A behavioural model predicts every output each cycle; directed phases add
// literal expectations, then a randomized phase runs against the model.
module tb_motor_pwm_ramp;

   localparam int NCH   = 3;
   localparam int MAXC  = 1023;
   localparam int PER   = 1024;

   logic        clk;
   logic        rst_n;
   logic [10:0] cmd_a0, cmd_a1, cmd_b;
   logic        brake_a0, brake_a1;
   logic [0:0]  brake_b;
   logic [21:0] cmd_a;
   logic [1:0]  brake_a;
   logic [1:0]  fwd_a, rev_a;
   logic [19:0] duty_a;
   logic        pe_a;
   logic [0:0]  fwd_b, rev_b;
   logic [9:0]  duty_b;
   logic        pe_b;

   assign cmd_a   = {cmd_a1, cmd_a0};
   assign brake_a = {brake_a1, brake_a0};

   motor_pwm_ramp #(.CH(2), .W(10), .STEP(8), .DEAD(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_a), .brake(brake_a),
      .fwd(fwd_a), .rev(rev_a), .duty_mon(duty_a), .period_end(pe_a)
   );

   motor_pwm_ramp #(.CH(1), .W(10), .STEP(1000), .DEAD(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_b), .brake(brake_b),
      .fwd(fwd_b), .rev(rev_b), .duty_mon(duty_b), .period_end(pe_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string nm, input int ch, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s ch%0d: got %0d expected %0d at t=%0t", nm, ch, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int m_cnt = 0;
   int m_mag[NCH];
   int m_dir[NCH];
   int m_dead[NCH];            // remaining coast clocks, 0 = running
   int m_fwd[NCH];
   int m_rev[NCH];
   int m_step[NCH]  = '{8, 8, 1000};
   int m_deadp[NCH] = '{16, 16, 0};

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [10:0] get_cmd(input int k);
      if (k == 0) return cmd_a0;
      if (k == 1) return cmd_a1;
      return cmd_b;
   endfunction

   function automatic int get_brake(input int k);
      if (k == 0) return int'(brake_a0);
      if (k == 1) return int'(brake_a1);
      return int'(brake_b[0]);
   endfunction

   function automatic int get_fwd(input int k);
      return (k < 2) ? int'(fwd_a[k]) : int'(fwd_b[0]);
   endfunction

   function automatic int get_rev(input int k);
      return (k < 2) ? int'(rev_a[k]) : int'(rev_b[0]);
   endfunction

   function automatic int get_duty(input int k);
      return (k < 2) ? int'(duty_a[k*10 +: 10]) : int'(duty_b);
   endfunction

   always @(posedge clk) begin
      logic [10:0] c;
      int tm, td, bk;
      if (!rst_n) begin
         m_cnt = 0;
         for (int k = 0; k < NCH; k++) begin
            m_mag[k] = 0; m_dir[k] = 0; m_dead[k] = 0; m_fwd[k] = 0; m_rev[k] = 0;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            c  = get_cmd(k);
            tm = int'(c[9:0]);
            td = int'(c[10]);
            bk = get_brake(k);
            if (bk != 0)            begin m_fwd[k] = 1; m_rev[k] = 1; end
            else if (m_dead[k] > 0) begin m_fwd[k] = 0; m_rev[k] = 0; end
            else if (m_mag[k] == 0) begin m_fwd[k] = 1; m_rev[k] = 1; end
            else if (m_dir[k] == 0) begin m_fwd[k] = (m_mag[k] > m_cnt) ? 1 : 0; m_rev[k] = 0; end
            else                    begin m_fwd[k] = 0; m_rev[k] = (m_mag[k] > m_cnt) ? 1 : 0; end

            if (bk != 0) begin
               m_mag[k] = 0; m_dead[k] = 0;
            end else if (m_dead[k] > 0) begin
               m_dead[k]--;
            end else if (m_cnt == MAXC) begin
               if (tm == 0 || td == m_dir[k]) begin
                  if (tm > m_mag[k]) m_mag[k] += imin(m_step[k], tm - m_mag[k]);
                  else               m_mag[k] -= imin(m_step[k], m_mag[k] - tm);
               end else if (m_mag[k] > 0) begin
                  m_mag[k] -= imin(m_step[k], m_mag[k]);
               end else begin
                  m_dir[k]  = td;
                  m_dead[k] = m_deadp[k];
               end
            end
         end
         m_cnt = (m_cnt + 1) % PER;
      end
      #1;
      for (int k = 0; k < NCH; k++) begin
         check("fwd", k, get_fwd(k), m_fwd[k]);
         check("rev", k, get_rev(k), m_rev[k]);
         check("duty_mon", k, get_duty(k), m_mag[k]);
      end
      check("period_end_a", 0, int'(pe_a), (m_cnt == MAXC) ? 1 : 0);
      check("period_end_b", 2, int'(pe_b), (m_cnt == MAXC) ? 1 : 0);
   end

   // ---------------- stimulus helpers ----------------
   // Returns at the negedge right after the next boundary posedge.
   task automatic wait_boundary();
      while (m_cnt != MAXC) @(negedge clk);
      @(negedge clk);
   endtask

   // Counts gate activity over one full period starting at the next clock.
   task automatic count_period(input int k, output int nf, output int nr, output int nboth, output int ncoast);
      nf = 0; nr = 0; nboth = 0; ncoast = 0;
      repeat (PER) begin
         @(negedge clk);
         nf += get_fwd(k);
         nr += get_rev(k);
         if (get_fwd(k) == 1 && get_rev(k) == 1) nboth++;
         if (get_fwd(k) == 0 && get_rev(k) == 0) ncoast++;
      end
   endtask

   function automatic logic [10:0] rnd_cmd();
      logic [9:0] m;
      m = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 48));
      return {1'($urandom_range(0, 1)), m};
   endfunction

   initial begin
      int nf, nr, nb, nc;
      rst_n = 1'b0; cmd_a0 = '0; cmd_a1 = '0; cmd_b = '0;
      brake_a0 = 1'b0; brake_a1 = 1'b0; brake_b = '0;

      // Reset and release.
      repeat (3) @(negedge clk);
      check("rst_fwd", 0, int'(fwd_a), 0);
      check("rst_rev", 0, int'(rev_a), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_fwd", 0, int'(fwd_a), 3);
      check("idle_rev", 0, int'(rev_a), 3);
      check("idle_duty", 0, int'(duty_a), 0);

      fork
         begin // forward ramp to 64 on channel 0
            cmd_a0 = 11'h040;
            for (int i = 1; i <= 8; i++) begin
               wait_boundary();
               check("ramp_up", 0, get_duty(0), 8 * i);
            end
            check("model_ramp_up", 0, m_mag[0], 64);
            count_period(0, nf, nr, nb, nc);
            check("hold64_fwd_cnt", 0, nf, 64);
            check("hold64_rev_cnt", 0, nr, 0);
            check("ch1_passive_brake", 1, int'(fwd_a[1] & rev_a[1]), 1);
         end
         begin // saturation and zero dead-time reversal on instance B
            cmd_b = 11'h3FC;
            wait_boundary(); check("sat_step1", 2, get_duty(2), 1000);
            wait_boundary(); check("sat_step2", 2, get_duty(2), 1020);
            cmd_b = 11'h3FF;
            wait_boundary(); check("sat_max", 2, get_duty(2), 1023);
            count_period(2, nf, nr, nb, nc);
            check("sat_fwd_cnt", 2, nf, 1023);
            cmd_b = 11'h7FF;
            wait_boundary(); check("b_down1", 2, get_duty(2), 23);
            wait_boundary(); check("b_down0", 2, get_duty(2), 0);
            wait_boundary();
            count_period(2, nf, nr, nb, nc);
            check("b_no_coast", 2, nc, 0);
            check("b_passive", 2, nb, PER);
            check("b_rev_ramp", 2, get_duty(2), 1000);
            count_period(2, nf, nr, nb, nc);
            check("b_rev_cnt", 2, nr, 1000);
            check("b_fwd_cnt", 2, nf, 0);
         end
      join

      fork
         begin // reversal of channel 0 with dead-time
            cmd_a0 = 11'h440;
            for (int i = 1; i <= 8; i++) begin
               wait_boundary();
               check("ramp_down", 0, get_duty(0), 64 - 8 * i);
            end
            wait_boundary();
            nc = 0;
            repeat (20) begin
               @(negedge clk);
               if (fwd_a[0] == 1'b0 && rev_a[0] == 1'b0) nc++;
            end
            check("dead_len", 0, nc, 16);
            check("post_dead_passive", 0, int'(fwd_a[0] & rev_a[0]), 1);
            for (int i = 1; i <= 8; i++) begin
               wait_boundary();
               check("rev_ramp", 0, get_duty(0), 8 * i);
            end
            count_period(0, nf, nr, nb, nc);
            check("rev64_rev_cnt", 0, nr, 64);
            check("rev64_fwd_cnt", 0, nf, 0);
         end
         begin // brake mid-ramp on channel 1
            cmd_a1 = 11'h200;
            repeat (5) wait_boundary();
            check("pre_brake", 1, get_duty(1), 40);
            check("model_pre_brake", 1, m_mag[1], 40);
            brake_a1 = 1'b1;
            @(negedge clk);
            brake_a1 = 1'b0;
            check("brake_gates", 1, int'(fwd_a[1] & rev_a[1]), 1);
            check("brake_duty", 1, get_duty(1), 0);
            wait_boundary(); check("brake_resume1", 1, get_duty(1), 8);
            wait_boundary(); check("brake_resume2", 1, get_duty(1), 16);
         end
      join

      // Reset in the middle of a dead-time window.
      brake_a0 = 1'b1;
      @(negedge clk);
      brake_a0 = 1'b0;
      cmd_a0 = 11'h040;
      wait_boundary();
      repeat (5) @(negedge clk);
      check("in_dead", 0, int'(fwd_a[0] | rev_a[0]), 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_dead_fwd", 0, int'(fwd_a), 0);
      check("rst_dead_rev", 0, int'(rev_a), 0);
      check("rst_dead_duty", 0, int'(duty_a), 0);
      check("rst_dead_pe", 0, int'(pe_a), 0);
      wait_boundary(); check("rst_ramp1", 0, get_duty(0), 8);
      wait_boundary(); check("rst_ramp2", 0, get_duty(0), 16);
      count_period(0, nf, nr, nb, nc);
      check("rst_fwd_cnt", 0, nf, 16);
      check("rst_rev_cnt", 0, nr, 0);

      // Randomized traffic, including brakes and one reset, checked by the model.
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         brake_a0 = 1'b0; brake_a1 = 1'b0; brake_b = '0;
         rst_n = (i == 6000 || i == 6001) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 199) == 0) cmd_a0 = rnd_cmd();
         if ($urandom_range(0, 199) == 0) cmd_a1 = rnd_cmd();
         if ($urandom_range(0, 299) == 0) cmd_b  = rnd_cmd();
         if ($urandom_range(0, 599) == 0) brake_a0 = 1'b1;
         if ($urandom_range(0, 599) == 0) brake_a1 = 1'b1;
         if ($urandom_range(0, 799) == 0) brake_b  = 1'b1;
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
